// File: rtl/mor1kx_dpram_pkg.sv
// rtl/mor1kx_dpram_pkg.sv - shared types and helpers for the byte-enable dual-port RAM
package mor1kx_dpram_pkg;

  localparam int BYTE = 8;

  typedef enum logic {
    CLEAR,
    READY
  } clear_state_e;

  function automatic int num_bytes(input int data_width);
    return data_width / BYTE;
  endfunction

endpackage

// File: rtl/mor1kx_dpram_clear_fsm.sv
// rtl/mor1kx_dpram_clear_fsm.sv - post-reset sweep writing CLEAR_VALUE to every word
module mor1kx_dpram_clear_fsm
  import mor1kx_dpram_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 8,
  parameter int                    DATA_WIDTH  = 32,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  init_busy,
  output logic                  clr_we,
  output logic [ADDR_WIDTH-1:0] clr_addr,
  output logic [DATA_WIDTH-1:0] clr_data
);

  clear_state_e          state, state_nxt;
  logic [ADDR_WIDTH-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // The reset edge itself must not touch the array, so the sweep write is masked by rst.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    clr_we    = 1'b0;
    if (state == CLEAR && !rst) begin
      clr_we  = 1'b1;
      cnt_nxt = cnt + 1'b1;
      if (cnt == '1)
        state_nxt = READY;
    end
  end

  assign init_busy = (state == CLEAR);
  assign clr_addr  = cnt;
  assign clr_data  = CLEAR_VALUE;

endmodule

// File: rtl/mor1kx_dpram_sclk_be.sv
// rtl/mor1kx_dpram_sclk_be.sv - single-clock 1R1W RAM with byte enables and read bypass
// Optional clear engine compiled in with MOR1KX_DPRAM_CLEAR_EN.
module mor1kx_dpram_sclk_be
  import mor1kx_dpram_pkg::*;
#(
  parameter int                    ADDR_WIDTH    = 8,
  parameter int                    DATA_WIDTH    = 32,
  parameter int                    ENABLE_BYPASS = 1,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE   = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   raddr,
  input  logic                    re,
  input  logic [ADDR_WIDTH-1:0]   waddr,
  input  logic                    we,
  input  logic [DATA_WIDTH/8-1:0] wbe,
  input  logic [DATA_WIDTH-1:0]   din,
  output logic [DATA_WIDTH-1:0]   dout,
  output logic                    init_busy
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int NB    = num_bytes(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rdata;

  logic                  arr_we;
  logic [ADDR_WIDTH-1:0] arr_addr;
  logic [NB-1:0]         arr_be;
  logic [DATA_WIDTH-1:0] arr_data;
  logic                  rd_accept;

`ifdef MOR1KX_DPRAM_CLEAR_EN
  logic                  clr_we;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic [DATA_WIDTH-1:0] clr_data;

  mor1kx_dpram_clear_fsm #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .DATA_WIDTH  (DATA_WIDTH),
    .CLEAR_VALUE (CLEAR_VALUE)
  ) u_clear (
    .clk       (clk),
    .rst       (rst),
    .init_busy (init_busy),
    .clr_we    (clr_we),
    .clr_addr  (clr_addr),
    .clr_data  (clr_data)
  );

  assign arr_we   = clr_we | (we & ~init_busy & ~rst);
  assign arr_addr = clr_we ? clr_addr : waddr;
  assign arr_be   = clr_we ? {NB{1'b1}} : wbe;
  assign arr_data = clr_we ? clr_data : din;
`else
  assign init_busy = 1'b0;
  assign arr_we    = we & ~rst;
  assign arr_addr  = waddr;
  assign arr_be    = wbe;
  assign arr_data  = din;
`endif

  assign rd_accept = re & ~init_busy;

  always_ff @(posedge clk) begin
    if (arr_we) begin
      for (int i = 0; i < NB; i++) begin
        if (arr_be[i])
          mem[arr_addr][i*BYTE +: BYTE] <= arr_data[i*BYTE +: BYTE];
      end
    end
  end

  // Non-blocking read captures the word as it stood before this edge's write.
  always_ff @(posedge clk) begin
    if (rst)
      rdata <= '0;
    else if (rd_accept)
      rdata <= mem[raddr];
  end

  generate
    if (ENABLE_BYPASS != 0) begin : g_bypass
      logic                  bypass;
      logic [DATA_WIDTH-1:0] din_r;
      logic [NB-1:0]         wbe_r;

      always_ff @(posedge clk) begin
        if (rst) begin
          bypass <= 1'b0;
          din_r  <= '0;
          wbe_r  <= '0;
        end else if (rd_accept) begin
          bypass <= we && (raddr == waddr);
          if (we && (raddr == waddr)) begin
            din_r <= din;
            wbe_r <= wbe;
          end
        end
      end

      always_comb begin
        dout = rdata;
        for (int i = 0; i < NB; i++) begin
          if (bypass && wbe_r[i])
            dout[i*BYTE +: BYTE] = din_r[i*BYTE +: BYTE];
        end
      end
    end else begin : g_no_bypass
      assign dout = rdata;
    end
  endgenerate

endmodule

// File: doc/mor1kx_dpram_sclk_be.md
# mor1kx_dpram_sclk_be

Single-clock simple dual-port RAM (one read port, one write port) with per-byte write enables. Read-during-write to the same address returns byte-merged data through a bypass path. An optional post-reset clear engine sweeps the array to a known value. It is the next-generation storage primitive for caches, TLBs and NoC debug buffers, where partial writes and deterministic contents after reset are required.

## Interface
- ADDR_WIDTH, 8: address bits; depth DEPTH = 1<<ADDR_WIDTH words
- DATA_WIDTH, 32: word width; must be a multiple of 8
- ENABLE_BYPASS, 1: 1 = same-address read-during-write forwards new bytes; 0 = read returns old contents
- CLEAR_VALUE, 0: DATA_WIDTH-bit word written to every location by the clear engine

- clk  in  1  single clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- raddr  in  ADDR_WIDTH  read address
- re  in  1  read enable
- waddr  in  ADDR_WIDTH  write address
- we  in  1  write enable
- wbe  in  DATA_WIDTH/8  byte write enables; bit i covers din[8i+7:8i]
- din  in  DATA_WIDTH  write data
- dout  out  DATA_WIDTH  read data
- init_busy  out  1  clear sweep in progress; port accesses ignored

## Operation
- Write: on a rising edge with we=1 and init_busy=0, mem[waddr] byte i <= din byte i for each wbe[i]=1. Other bytes are unchanged. we=1 with wbe=0 is a no-op.
- Read: on a rising edge with re=1 and init_busy=0, the read register captures mem[raddr] as it was before this edge's write.
- Read hold: when re=0, dout holds its last value indefinitely. This includes the bypass selection.
- Bypass (ENABLE_BYPASS=1):
  - On an edge with re=1, we=1 and raddr==waddr, register din and wbe and set bypass=1.
  - On an edge with re=1 and no hit, clear bypass.
  - dout byte i = (bypass && wbe_r[i]) ? din_r byte i : rdata byte i. The result equals the post-write word.
- With ENABLE_BYPASS=0, dout is the registered pre-write word. The bypass logic is absent.
- Different-address simultaneous read and write proceed independently.
- Clear engine (when compiled in):
  - States CLEAR and READY.
  - rst forces CLEAR with cnt=0.
  - In CLEAR, each cycle writes CLEAR_VALUE to mem[cnt] (all bytes) and increments cnt.
  - The transition to READY happens on the edge that writes cnt==DEPTH-1.
  - init_busy = (state==CLEAR).
  - In CLEAR, we and re are ignored: no write, no read-register update, no bypass update.

## Timing
- Reset values: dout=0 (rdata=0, bypass=0, din_r=0, wbe_r=0).
- init_busy reset value: 1 with the clear engine, 0 without.
- Read latency: 1 cycle. raddr/re sampled at edge N produce dout after edge N, stable until the next edge with re=1.
- Write takes effect at the edge. A read of the same address at edge N+1 sees the new data.
- Clear duration: DEPTH cycles. init_busy falls after the DEPTH-th edge following the first edge with rst low. The first accepted access is on the next edge.
- Reset mid-sweep: the engine restarts at cnt=0. Locations already cleared are rewritten.
- rst has priority over we/re on the same edge. That edge performs no array write and no read.
- cnt is ADDR_WIDTH bits and wraps at DEPTH-1. No wrap occurs in READY because cnt is frozen.

## Configuration
- MOR1KX_DPRAM_CLEAR_EN defined:
  - The clear engine is present and memory equals CLEAR_VALUE everywhere when init_busy falls.
  - The array write port is muxed between the engine and the user.
- Undefined:
  - No engine is built; init_busy is tied 0 and array contents are undefined after reset.
  - Accesses are accepted on the first edge with rst low.
  - dout still resets to 0.

## Structure
- Package mor1kx_dpram_pkg holds:
  - clear state enum {CLEAR, READY}
  - localparam BYTE=8
  - function computing DATA_WIDTH/8
- Sub-module mor1kx_dpram_clear_fsm holds the state register, counter and init_busy. It outputs clr_we, clr_addr and clr_data, and is instantiated only under MOR1KX_DPRAM_CLEAR_EN.
- The top level holds the byte-lane array, the write mux, the read register and the bypass merge.

## Test plan
- Reset clear (macro on, ADDR_WIDTH=4, CLEAR_VALUE=32'hA5A5A5A5):
  - Release rst and count cycles: init_busy=1 for exactly 16 cycles.
  - Then read all 16 addresses: each returns 32'hA5A5A5A5 one cycle after re.
- Byte write: write 32'h11223344 wbe=4'hF to addr 3, then 32'hAABBCCDD wbe=4'b0101 to addr 3, then read addr 3 -> dout=32'h11BB33DD.
- Bypass merge:
  - addr 5 holds 32'h00000000. On one edge issue we=1, wbe=4'b1000, din=32'hFF000000, re=1, raddr=waddr=5.
  - ENABLE_BYPASS=1: dout=32'hFF000000 next cycle.
  - ENABLE_BYPASS=0: dout=32'h00000000; a following read returns 32'hFF000000.
- Hold: after dout=32'hFF000000, drive re=0 with writes to addr 5 for 10 cycles -> dout unchanged.
- Reset mid-sweep:
  - Assert rst for 1 cycle at sweep cycle 7, with we=1 during the sweep -> init_busy stays high 16 more cycles.
  - The attempted writes are not visible; all locations read CLEAR_VALUE.
- Macro off: init_busy=0 from reset. A write then read on consecutive edges after rst falls returns the written data with 1-cycle latency.
